// File: rtl/ftdi_sync_read_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ftdi_sync_read_ctrl_if
//
// Purpose: bundles the FTDI 245 synchronous-FIFO read-side pins and the
// downstream valid/ready stream of ftdi_sync_read_ctrl into one interface.
//
// Signals:
//   enable_i   read side owns the bus (from the read/write arbiter)
//   rxf_n_i    FTDI RXF#, low = data available
//   data_i     FTDI data bus (driven by the FTDI while oe_n_o is low)
//   oe_n_o     FTDI OE#
//   rd_n_o     FTDI RD#
//   m_data_o   head of the internal buffer
//   m_valid_o  buffer not empty
//   m_ready_i  downstream accepts m_data_o
//   busy_o     controller is inside an OE# window
//
// Modports:
//   master  the read controller
//   slave   the FTDI device plus the downstream consumer
// -----------------------------------------------------------------------------
interface ftdi_sync_read_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              enable_i;
    logic              rxf_n_i;
    logic [DATA_W-1:0] data_i;
    logic              oe_n_o;
    logic              rd_n_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic              busy_o;

    modport master (
        input  enable_i, rxf_n_i, data_i, m_ready_i,
        output oe_n_o, rd_n_o, m_data_o, m_valid_o, busy_o
    );

    modport slave (
        output enable_i, rxf_n_i, data_i, m_ready_i,
        input  oe_n_o, rd_n_o, m_data_o, m_valid_o, busy_o
    );
endinterface

// File: rtl/ftdi_sync_read_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ftdi_sync_read_ctrl
//
// Purpose: read controller for the FTDI 245-style synchronous FIFO, clocked by
// the FTDI CLKOUT. Opens an OE# window when data is available and there is
// room, strobes RD# while RXF# stays low, captures the bus into a small
// first-word-fall-through buffer and presents it on a valid/ready stream.
// Windows are bounded by buffer room, the optional burst limit and the
// arbiter's enable.
//
// Parameters:
//   DATA_W      width of the FTDI data bus and output stream
//   FIFO_DEPTH  buffer entries, power of 2, >= 2
//   MAX_BURST   max words captured per OE# window, 0 = unlimited
//
// Ports:
//   clk_i       FTDI CLKOUT, all logic on the rising edge
//   rst_i       asynchronous, active-high reset
//   bus         ftdi_sync_read_ctrl_if.master (FTDI pins + output stream)
//   rd_count_o  32-bit captured-word counter (only with FTDI_RD_STATS_EN)
//
// Build option:
//   FTDI_RD_STATS_EN  when defined, adds rd_count_o and its counter.
// -----------------------------------------------------------------------------
module ftdi_sync_read_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ftdi_sync_read_ctrl_if.master  bus
`ifdef FTDI_RD_STATS_EN
    ,
    output logic [31:0]            rd_count_o
`endif
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BCNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OE      = 2'd1,
        S_READ    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               oe_n_q, rd_n_q;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   occ_q, occ_next;
    logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_next;
    logic               push, pop, valid;
    logic               full_next, burst_hit;

    // A word is on the bus exactly when our registered RD# is low and the
    // FTDI still signals data; RD# high guarantees no write in any other case.
    assign valid = (occ_q != '0);
    assign push  = !rd_n_q && !bus.rxf_n_i;
    assign pop   = valid && bus.m_ready_i;

    always_comb begin
        occ_next = occ_q;
        if (push && !pop) begin
            occ_next = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_next = occ_q - OCC_W'(1);
        end
    end

    // Saturating so the unlimited build (1-bit counter) never wraps.
    always_comb begin
        burst_cnt_next = burst_cnt_q;
        if (push && (burst_cnt_q != '1)) begin
            burst_cnt_next = burst_cnt_q + BCNT_W'(1);
        end
    end

    assign full_next = (occ_next == OCC_W'(FIFO_DEPTH));
    assign burst_hit = (MAX_BURST != 0) && (burst_cnt_next == BCNT_W'(MAX_BURST));

    // Next-state logic. Leaving READ is decided with this edge's push already
    // counted, so the word captured on the exiting edge is never lost and the
    // buffer can never overflow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable_i && !bus.rxf_n_i &&
                    (occ_q <= OCC_W'(FIFO_DEPTH - 2))) begin
                    state_d = S_OE;
                end
            end
            S_OE: begin
                state_d = (bus.enable_i && !bus.rxf_n_i) ? S_READ : S_RELEASE;
            end
            S_READ: begin
                if (bus.rxf_n_i || !bus.enable_i || full_next || burst_hit) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // OE#/RD# are registered from the next state so the pins change on the
    // same edge as the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            oe_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            oe_n_q      <= (state_d == S_IDLE);
            rd_n_q      <= (state_d != S_READ);
            burst_cnt_q <= (state_q == S_OE) ? '0 : burst_cnt_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_next;
        end
    end

    // Storage carries data only; occupancy and pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data_i;
        end
    end

`ifdef FTDI_RD_STATS_EN
    logic [31:0] rd_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_count_q <= '0;
        end else if (push) begin
            rd_count_q <= rd_count_q + 32'd1;
        end
    end

    assign rd_count_o = rd_count_q;
`else
    // No capture statistics in this build.
`endif

    assign bus.oe_n_o    = oe_n_q;
    assign bus.rd_n_o    = rd_n_q;
    assign bus.m_data_o  = mem[rd_ptr_q];
    assign bus.m_valid_o = valid;
    assign bus.busy_o    = (state_q != S_IDLE);

endmodule
